// File: rtl/operand_read_if.sv
// Operand read bundle: write-back write port, read request handshake and registered operands.
// The master side is the pipeline (issue + write-back), the slave side is the register file.
interface operand_read_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              RWrEn;
  logic [ADDR_W-1:0] Rdst;
  logic [DATA_W-1:0] RWrdata;
  logic              rd_req;
  logic              rd_ready;
  logic [ADDR_W-1:0] Rs1;
  logic [ADDR_W-1:0] Rs2;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_rd_we;
  logic [DATA_W-1:0] RData1;
  logic [DATA_W-1:0] RData2;
  logic              rd_valid;

  modport master (
    output RWrEn, Rdst, RWrdata, rd_req, Rs1, Rs2, issue_rd, issue_rd_we,
    input  rd_ready, RData1, RData2, rd_valid
  );

  modport slave (
    input  RWrEn, Rdst, RWrdata, rd_req, Rs1, Rs2, issue_rd, issue_rd_we,
    output rd_ready, RData1, RData2, rd_valid
  );
endinterface

// File: rtl/operand_read.sv
// Register file read stage: two registered operand reads per request, busy scoreboard
// stalling on pending write-backs, and same-cycle write-back forwarding.
module operand_read #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input logic           clk,
  input logic           rst_n,
  operand_read_if.slave bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   rdata1_q, rdata2_q;
  logic                rd_valid_q;

  logic              wb_hit1, wb_hit2;
  logic              haz1, haz2;
  logic              accept;
  logic [DATA_W-1:0] op1, op2;

  always_comb begin
    wb_hit1 = bus.RWrEn && (bus.Rdst == bus.Rs1);
    wb_hit2 = bus.RWrEn && (bus.Rdst == bus.Rs2);
    haz1    = busy_q[bus.Rs1] && (bus.Rs1 != '0) && !wb_hit1;
    haz2    = busy_q[bus.Rs2] && (bus.Rs2 != '0) && !wb_hit2;
    op1     = (bus.Rs1 == '0) ? '0 : (wb_hit1 ? bus.RWrdata : regs_q[bus.Rs1]);
    op2     = (bus.Rs2 == '0) ? '0 : (wb_hit2 ? bus.RWrdata : regs_q[bus.Rs2]);
  end

  assign bus.rd_ready = !haz1 && !haz2;
  assign accept       = bus.rd_req && bus.rd_ready;

  // Set after clear: a newly issued producer outranks the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (bus.RWrEn) busy_d[bus.Rdst] = 1'b0;
    if (accept && bus.issue_rd_we) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (bus.RWrEn && (bus.Rdst != '0)) regs_q[bus.Rdst] <= bus.RWrdata;
      busy_q     <= busy_d;
      rd_valid_q <= accept;
      if (accept) begin
        rdata1_q <= op1;
        rdata2_q <= op2;
      end
    end
  end

  assign bus.RData1   = rdata1_q;
  assign bus.RData2   = rdata2_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_operand_read.sv
// Bench for operand_read: directed scenarios plus random traffic against an array model,
// with accepted requests scoreboarded and matched when rd_valid appears.
module tb_operand_read;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_read_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  operand_read #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] regs_m [32];
  logic        busy_m [32];
  logic [31:0] last1, last2;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] s, input logic wen,
                                       input logic [4:0] dst, input logic [31:0] wd);
    if (s == 5'd0) return 32'd0;
    if (wen && dst == s) return wd;
    return regs_m[s];
  endfunction

  function automatic logic stalls(input logic [4:0] s, input logic wen, input logic [4:0] dst);
    return busy_m[s] && s != 5'd0 && !(wen && dst == s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      regs_m[i] = '0;
      busy_m[i] = 1'b0;
    end
    exp_q.delete();
    last1 = '0;
    last2 = '0;
  endtask

  // Monitor: pops the scoreboard on rd_valid, otherwise operands must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got rd_valid=1, expected no pending request");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency", cyc, e.cyc + 1);
          chk("RData1", bus.RData1, e.d1);
          chk("RData2", bus.RData2, e.d2);
          last1 = e.d1;
          last2 = e.d2;
        end
      end else begin
        chk("hold1", bus.RData1, last1);
        chk("hold2", bus.RData2, last2);
      end
    end
  end

  task automatic step(input logic wen, input logic [4:0] dst, input logic [31:0] wd,
                      input logic req, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] ird, input logic iwe, output logic acc);
    logic rdy;
    exp_t e;
    @(negedge clk);
    bus.RWrEn = wen; bus.Rdst = dst; bus.RWrdata = wd;
    bus.rd_req = req; bus.Rs1 = s1; bus.Rs2 = s2;
    bus.issue_rd = ird; bus.issue_rd_we = iwe;
    #1;
    rdy = !stalls(s1, wen, dst) && !stalls(s2, wen, dst);
    chk("rd_ready", {31'd0, bus.rd_ready}, {31'd0, rdy});
    acc = req && rdy;
    if (acc) begin
      e.cyc = cyc;
      e.d1  = opnd(s1, wen, dst, wd);
      e.d2  = opnd(s2, wen, dst, wd);
      exp_q.push_back(e);
    end
    if (wen && dst != 5'd0) regs_m[dst] = wd;
    if (wen) busy_m[dst] = 1'b0;
    if (acc && iwe && ird != 5'd0) busy_m[ird] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    bus.rd_req = 1'b0;
    bus.RWrEn  = 1'b0;
    rst_n      = 1'b0;
    #1;
    model_clear();
    chk("rst_RData1", bus.RData1, 32'd0);
    chk("rst_RData2", bus.RData2, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic        a;
    logic        hold;
    logic        wen, req, iwe;
    logic [4:0]  dst, s1, s2, ird;
    logic [31:0] wd;

    bus.RWrEn = 0; bus.Rdst = 0; bus.RWrdata = 0; bus.rd_req = 0;
    bus.Rs1 = 0; bus.Rs2 = 0; bus.issue_rd = 0; bus.issue_rd_we = 0;
    model_clear();
    do_reset();

    // Plain write then read
    step(1, 5'd3, 32'h0000_00AA, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 5'd3, 5'd0, 0, 0, a);
    // Write to x0 is dropped
    step(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 5'd0, 5'd0, 0, 0, a);
    // Scoreboard stall on x7, released by forwarded write-back
    step(0, 0, 0, 1, 5'd1, 5'd2, 5'd7, 1, a);
    repeat (3) step(0, 0, 0, 1, 5'd0, 5'd7, 0, 0, a);
    step(1, 5'd7, 32'h0000_1234, 1, 5'd0, 5'd7, 0, 0, a);
    step(0, 0, 0, 1, 5'd7, 5'd7, 0, 0, a);
    // Simultaneous set and clear on x9
    step(1, 5'd9, 32'h0000_0099, 1, 5'd0, 5'd0, 5'd9, 1, a);
    repeat (2) step(0, 0, 0, 1, 5'd9, 5'd0, 0, 0, a);
    step(1, 5'd9, 32'h0000_0999, 1, 5'd9, 5'd0, 0, 0, a);
    // Self-source issue on x4
    step(1, 5'd4, 32'h0000_0010, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 5'd4, 5'd0, 5'd4, 1, a);
    repeat (2) step(0, 0, 0, 1, 5'd4, 5'd0, 0, 0, a);
    step(1, 5'd4, 32'h0000_0055, 1, 5'd4, 5'd4, 0, 0, a);

    // Random traffic; a stalled request is held until accepted
    hold = 0; s1 = 0; s2 = 0; ird = 0; iwe = 0;
    for (int n = 0; n < 1500; n++) begin
      wen = ($urandom_range(0, 1) == 1);
      dst = 5'($urandom_range(0, 31));
      wd  = $urandom;
      if (hold) begin
        req = 1;
        if ($urandom_range(0, 1) == 1) begin
          wen = 1;
          dst = busy_m[s2] ? s2 : s1;
        end
      end else begin
        req = ($urandom_range(0, 3) != 0);
        s1  = 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31));
        s2  = 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31));
        ird = 5'($urandom_range(0, 7));
        iwe = ($urandom_range(0, 2) != 0);
      end
      step(wen, dst, wd, req, s1, s2, ird, iwe, a);
      hold = req && !a;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, a);

    // Reset mid-run discards written contents
    step(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 5'd5, 5'd0, 5'd6, 1, a);
    do_reset();
    step(0, 0, 0, 1, 5'd5, 5'd6, 0, 0, a);
    step(1, 5'd6, 32'h0000_0066, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 5'd6, 5'd0, 0, 0, a);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, a);
    chk("drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_read.md
# operand_read

Register file read side of the pipeline and the consumer of the write-back stage's output. It holds the 32 architectural registers and accepts the write-back write (`RWrdata` to `Rdst` when `RWrEn` is high). It serves two source-operand reads per request through a valid/ready handshake. A per-register busy scoreboard stalls any request whose sources still await write-back. A same-cycle write to a requested source is forwarded, so the request does not stall.

## Interface
Parameters:
- `DATA_W`, 32, register and data width
- `ADDR_W`, 5, register index width
- `NUM_REGS`, 32, number of registers (2**ADDR_W); index 0 is hardwired zero

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `RWrEn`  in  1  write-back write enable
- `Rdst`  in  ADDR_W  write-back destination register
- `RWrdata`  in  DATA_W  write-back data (from write_back mux)
- `rd_req`  in  1  operand read request valid
- `rd_ready`  out  1  request accepted this cycle when `rd_req` is also high (combinational)
- `Rs1`, `Rs2`  in  ADDR_W  source register indices
- `issue_rd`  in  ADDR_W  destination of the requesting instruction
- `issue_rd_we`  in  1  requesting instruction will write `issue_rd`
- `RData1`, `RData2`  out  DATA_W  registered operands
- `rd_valid`  out  1  one-cycle pulse: `RData1`/`RData2` hold operands of the last accepted request

## Operation
- Storage: `regs[1..NUM_REGS-1]` flops. Reads of index 0 return 0. Writes to index 0 are ignored.
- Write: on a rising edge with `RWrEn`=1 and `Rdst`≠0, `regs[Rdst]` ← `RWrdata`.
- Scoreboard: one `busy` bit per register; `busy[0]` is constantly 0.
  - Set on acceptance (`rd_req && rd_ready`) when `issue_rd_we`=1 and `issue_rd`≠0.
  - Cleared on a write-back with `RWrEn`=1 to `Rdst`.
  - If set and clear hit the same register in one cycle, set wins, because the newer producer is outstanding.
- Hazard per source `s` (`Rs1` or `Rs2`): `busy[s]` && `s`≠0 && !(`RWrEn` && `Rdst`==`s`).
- `rd_ready` = no hazard on `Rs1` and no hazard on `Rs2`. It depends only on current state and current inputs, not on `rd_req`.
- Operand select per source `s`:
  - `s`==0 → 0.
  - else `RWrEn` && `Rdst`==`s` → `RWrdata` (bypass).
  - else `regs[s]`.
- On acceptance, `RData1`/`RData2` capture the selected operands and `rd_valid` is 1 the next cycle. Otherwise `rd_valid` is 0 and `RData1`/`RData2` hold their previous values.
- If `issue_rd` equals `Rs1` or `Rs2`, the request reads the pre-issue value, then marks that register busy.
- No write-back arrives for a register that is not busy. Such a write still updates `regs` and leaves `busy` clear.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - all `regs`=0, all `busy`=0
  - `RData1`=0, `RData2`=0, `rd_valid`=0
  - `rd_ready` follows its combinational rule, so it is 1 with the scoreboard clear.
- Reset asserted mid-operation discards all pending scoreboard bits and register contents immediately. After release, a write-back for a pre-reset issue only updates `regs`.
- Read latency: 1 cycle from the accepting edge to `rd_valid`/`RData*`.
- Write-to-read: a write at edge N is visible to a request accepted at edge N via bypass, and via `regs` from edge N+1 on.
- Throughput: one request per cycle when there are no hazards.
- A stalled request (`rd_req`=1, `rd_ready`=0) must be held stable by the requester until accepted. The block keeps no record of it.

## Test plan
- Reset check: assert `rst_n`=0 mid-run after writes.
  - → `RData1`=`RData2`=0, `rd_valid`=0, `rd_ready`=1.
  - → a following read of x5 returns 0.
- Plain write/read: write x3=0x0000_00AA. Next cycle request `Rs1`=3, `Rs2`=0.
  - → `rd_ready`=1, then `rd_valid`=1 with `RData1`=0xAA, `RData2`=0.
- Write to x0: `RWrEn`=1, `Rdst`=0, `RWrdata`=0xFFFF_FFFF, then read `Rs1`=0.
  - → `RData1`=0.
- Scoreboard stall: accept an issue with `issue_rd`=7, `issue_rd_we`=1. Next request has `Rs2`=7.
  - → `rd_ready`=0 for 3 cycles with no write-back.
  - → write-back x7=0x1234 arrives: same cycle `rd_ready`=1, next cycle `RData2`=0x1234, `busy[7]` cleared.
- Simultaneous set/clear: in one cycle, write-back to x9 while accepting an issue with `issue_rd`=9.
  - → `busy[9]`=1 afterwards.
  - → next request with `Rs1`=9 stalls until a second write-back to x9.
- Self-source issue: `Rs1`=4=`issue_rd`, with x4=0x10.
  - → accepted with `RData1`=0x10.
  - → next request reading x4 stalls.
